// File: rtl/axi_burst_ram_slave.sv
// axi_burst_ram_slave: AXI3 word RAM slave with independent read/write FSMs and programmable read latency
module axi_burst_ram_slave #(
    parameter int ADDR_W = 10,
    parameter int ID_W   = 4,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [31:0]       s_araddr,
    input  logic [7:0]        s_arlen,
    input  logic [2:0]        s_arsize,
    input  logic [1:0]        s_arburst,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [ID_W-1:0]   s_rid,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready,
    input  logic [ID_W-1:0]   s_awid,
    input  logic [31:0]       s_awaddr,
    input  logic [7:0]        s_awlen,
    input  logic [2:0]        s_awsize,
    input  logic [1:0]        s_awburst,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [ID_W-1:0]   s_wid,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wlast,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [ID_W-1:0]   s_bid,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready
);
    localparam int AW = ADDR_W + 2;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] mem [2**ADDR_W];

    r_state_t r_state, r_next;
    w_state_t w_state, w_next;
    logic [AW-1:0] r_addr, r_addr_nx, w_addr, w_addr_nx;
    logic [ADDR_W-1:0] r_idx;
    logic [7:0] r_len, r_beat, w_len, w_beat, lat_cnt;
    logic [2:0] r_size, w_size;
    logic [1:0] r_burst, w_burst;
    logic r_fetch, r_adv, w_fire, w_end;
    logic unused_ok;

    assign unused_ok = ^{s_wid, s_araddr[31:AW], s_awaddr[31:AW]};

    assign s_arready = r_state == R_IDLE;
    assign s_rvalid  = r_state == R_DATA;
    assign s_rlast   = s_rvalid && r_beat == r_len;
    assign s_awready = w_state == W_IDLE;
    assign s_wready  = w_state == W_DATA;
    assign s_bvalid  = w_state == W_RESP;

    // Addresses are kept only ADDR_W+2 bits wide so they alias around the array
    assign r_addr_nx = r_addr + ((r_burst == 2'b00) ? AW'(0) : AW'(1) << r_size);
    assign w_addr_nx = w_addr + ((w_burst == 2'b00) ? AW'(0) : AW'(1) << w_size);
    assign r_idx     = r_adv ? r_addr_nx[AW-1:2] : r_addr[AW-1:2];
    assign w_fire    = s_wready && s_wvalid;
    assign w_end     = w_fire && (s_wlast || w_beat == w_len);

    always_comb begin
        r_next  = r_state;
        r_fetch = 1'b0;
        r_adv   = 1'b0;
        if (r_state == R_IDLE && s_arvalid)
            r_next = R_WAIT;
        if (r_state == R_WAIT && lat_cnt == 8'd0) begin
            r_next  = R_DATA;
            r_fetch = 1'b1;
        end
        if (r_state == R_DATA && s_rready) begin
            r_next  = (r_beat == r_len) ? R_IDLE : R_DATA;
            r_fetch = r_beat != r_len;
            r_adv   = r_beat != r_len;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            s_rid   <= '0;
            s_rdata <= '0;
            s_rresp <= 2'b00;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_size  <= '0;
            r_burst <= '0;
            lat_cnt <= '0;
        end else begin
            r_state <= r_next;
            if (s_arready && s_arvalid) begin
                s_rid   <= s_arid;
                r_addr  <= s_araddr[AW-1:0];
                r_len   <= s_arlen;
                r_size  <= s_arsize;
                r_burst <= s_arburst;
                r_beat  <= '0;
                lat_cnt <= 8'(RD_LAT - 1);
                s_rresp <= (s_arburst == 2'b11) ? 2'b10 : 2'b00;
            end
            if (r_state == R_WAIT && lat_cnt != 8'd0)
                lat_cnt <= lat_cnt - 8'd1;
            if (r_fetch)
                s_rdata <= mem[r_idx];
            if (r_adv) begin
                r_addr <= r_addr_nx;
                r_beat <= r_beat + 8'd1;
            end
        end
    end

    always_comb begin
        w_next = w_state;
        if (w_state == W_IDLE && s_awvalid)
            w_next = W_DATA;
        if (w_end)
            w_next = W_RESP;
        if (w_state == W_RESP && s_bready)
            w_next = W_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            s_bid   <= '0;
            s_bresp <= 2'b00;
            w_addr  <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_size  <= '0;
            w_burst <= '0;
        end else begin
            w_state <= w_next;
            if (s_awready && s_awvalid) begin
                s_bid   <= s_awid;
                w_addr  <= s_awaddr[AW-1:0];
                w_len   <= s_awlen;
                w_size  <= s_awsize;
                w_burst <= s_awburst;
                w_beat  <= '0;
            end
            if (w_fire)
                w_addr <= w_addr_nx;
            if (w_fire && !w_end)
                w_beat <= w_beat + 8'd1;
            // A burst that ends early, runs past len, or uses the reserved type is an error
            if (w_end)
                s_bresp <= (w_burst == 2'b11 || s_wlast != (w_beat == w_len)) ? 2'b10 : 2'b00;
        end
    end

    always_ff @(posedge clk)
        for (int k = 0; k < 4; k++)
            if (w_fire && s_wstrb[k])
                mem[w_addr[AW-1:2]][8*k +: 8] <= s_wdata[8*k +: 8];
endmodule
